// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequences PC, requests instruction words from
// instruction memory, holds the fetched instruction until it retires and
// stops permanently (until reset) on a misaligned next PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic [31:0] ImmExt,
    input  logic        retire,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic        misalign,
    output logic [15:0] fetch_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        VALID,
        HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic        pc_aligned;
    logic        fetching;
    logic        retiring;

    assign PCPlus4    = PC + 32'd4;
    assign imem_addr  = PC;
    assign pc_next    = PCSrc ? (PC + ImmExt) : PCPlus4;
    assign pc_aligned = (pc_next[1:0] == 2'b00);
    assign fetching   = (state == REQ) || (state == WAIT);
    assign retiring   = (state == VALID) && retire;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = REQ;
            REQ:     state_next = imem_ack ? VALID : WAIT;
            WAIT:    state_next = imem_ack ? VALID : WAIT;
            VALID: begin
                if (retire) begin
                    state_next = pc_aligned ? REQ : HALT;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    // Outputs decoded from the current state; misalign is sticky because HALT is terminal
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        misalign    = 1'b0;
        case (state)
            REQ, WAIT: imem_req    = 1'b1;
            VALID:     instr_valid = 1'b1;
            HALT:      misalign    = 1'b1;
            default:   ;
        endcase
    end

    // Datapath: PC advance on aligned retire, instruction capture and count on ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC          <= RESET_PC;
            Instr       <= NOP;
            fetch_count <= '0;
        end else begin
            if (retiring && pc_aligned) begin
                PC <= pc_next;
            end
            if (fetching && imem_ack) begin
                Instr       <= imem_rdata;
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios pinned by literal
// expectations plus a randomized run compared every cycle against a
// transaction-level model of the fetch/hold/retire behaviour.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        PCSrc;
    logic [31:0] ImmExt;
    logic        retire;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        misalign;
    logic [15:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCSrc       (PCSrc),
        .ImmExt      (ImmExt),
        .retire      (retire),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .instr_valid (instr_valid),
        .misalign    (misalign),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: what the unit is doing, expressed as "waiting one boot cycle",
    // "waiting for memory", "holding an instruction", "stopped".
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [15:0] m_count;
    bit          m_boot;
    bit          m_fetch;
    bit          m_hold;
    bit          m_halt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_0000;
        m_instr = 32'h0000_0013;
        m_count = 16'd0;
        m_boot  = 1'b1;
        m_fetch = 1'b0;
        m_hold  = 1'b0;
        m_halt  = 1'b0;
    endtask

    task automatic compare_all();
        check("imem_req",    {31'd0, imem_req},    {31'd0, m_fetch});
        check("instr_valid", {31'd0, instr_valid}, {31'd0, m_hold});
        check("misalign",    {31'd0, misalign},    {31'd0, m_halt});
        check("PC",          PC,                   m_pc);
        check("imem_addr",   imem_addr,            m_pc);
        check("PCPlus4",     PCPlus4,              m_pc + 32'd4);
        check("Instr",       Instr,                m_instr);
        check("fetch_count", {16'd0, fetch_count}, {16'd0, m_count});
    endtask

    // Advance one clock: predict from the inputs now applied, then compare on the falling edge.
    task automatic tick();
        logic [31:0] target;
        logic [31:0] n_pc;
        logic [31:0] n_instr;
        logic [15:0] n_count;
        bit n_boot, n_fetch, n_hold, n_halt;
        n_pc = m_pc; n_instr = m_instr; n_count = m_count;
        n_boot = m_boot; n_fetch = m_fetch; n_hold = m_hold; n_halt = m_halt;
        if (!rst) begin
            n_pc = 32'h0; n_instr = 32'h13; n_count = 16'd0;
            n_boot = 1; n_fetch = 0; n_hold = 0; n_halt = 0;
        end else if (m_halt) begin
            // stopped until reset
        end else if (m_boot) begin
            n_boot = 0; n_fetch = 1;
        end else if (m_fetch) begin
            if (imem_ack) begin
                n_instr = imem_rdata;
                n_count = m_count + 16'd1;
                n_fetch = 0; n_hold = 1;
            end
        end else if (m_hold && retire) begin
            target = m_pc + (PCSrc ? ImmExt : 32'd4);
            n_hold = 0;
            if (target % 4 == 0) begin
                n_pc = target; n_fetch = 1;
            end else begin
                n_halt = 1;
            end
        end
        @(posedge clk);
        m_pc = n_pc; m_instr = n_instr; m_count = n_count;
        m_boot = n_boot; m_fetch = n_fetch; m_hold = n_hold; m_halt = n_halt;
        @(negedge clk);
        compare_all();
    endtask

    task automatic retire_go(input logic src, input logic [31:0] imm);
        retire = 1'b1; PCSrc = src; ImmExt = imm;
        tick();
        retire = 1'b0; PCSrc = 1'b0; ImmExt = '0;
    endtask

    task automatic fetch_now(input logic [31:0] word);
        imem_ack = 1'b1; imem_rdata = word;
        tick();
        imem_ack = 1'b0;
    endtask

    initial begin
        int req_cycles;
        logic [15:0] count_before;
        logic [31:0] pc_before;
        logic [31:0] r;

        rst = 1'b0; PCSrc = 1'b0; ImmExt = '0; retire = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        // Reset values
        check("rst_PC", PC, 32'h0);
        check("rst_Instr", Instr, 32'h0000_0013);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_count", {16'd0, fetch_count}, 32'd0);

        // First fetch with ack tied high
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        tick();
        check("first_instr", Instr, 32'h0050_0093);
        check("first_valid", {31'd0, instr_valid}, 32'd1);
        check("first_count", {16'd0, fetch_count}, 32'd1);
        imem_ack = 1'b0;

        // Sequential walk to 0x10
        for (int unsigned k = 0; k < 4; k++) begin
            retire_go(1'b0, 32'h0);
            fetch_now($urandom);
        end
        check("seq_PC", PC, 32'h10);
        check("seq_PCPlus4", PCPlus4, 32'h14);
        retire_go(1'b0, 32'h1234_5671);
        check("seq_next_addr", imem_addr, 32'h14);
        fetch_now($urandom);
        for (int unsigned k = 0; k < 3; k++) begin
            retire_go(1'b0, 32'h0);
            fetch_now($urandom);
        end
        check("br_start_PC", PC, 32'h20);
        retire_go(1'b1, 32'hFFFF_FFF0);
        check("br_taken_PC", PC, 32'h10);
        fetch_now($urandom);

        // Wait states: ack delayed three cycles
        count_before = fetch_count;
        req_cycles = 0;
        retire_go(1'b0, 32'h0);
        pc_before = imem_addr;
        if (imem_req) req_cycles++;
        for (int unsigned k = 0; k < 3; k++) begin
            imem_rdata = $urandom;
            tick();
            check("wait_addr_stable", imem_addr, pc_before);
            if (imem_req) req_cycles++;
        end
        fetch_now(32'hCAFE_0013);
        check("wait_req_cycles", req_cycles, 32'd4);
        check("wait_instr", Instr, 32'hCAFE_0013);
        check("wait_count", {16'd0, fetch_count}, {16'd0, count_before + 16'd1});

        // PC wraps to zero
        retire_go(1'b1, 32'hFFFF_FFFC - m_pc);
        fetch_now($urandom);
        check("wrap_PC", PC, 32'hFFFF_FFFC);
        check("wrap_PCPlus4", PCPlus4, 32'h0);
        retire_go(1'b0, 32'h0);
        check("wrap_next_PC", PC, 32'h0);
        fetch_now($urandom);

        // Misaligned branch halts
        retire_go(1'b1, 32'h2);
        check("mis_flag", {31'd0, misalign}, 32'd1);
        check("mis_PC", PC, 32'h0);
        check("mis_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b1; retire = 1'b1;
        for (int unsigned k = 0; k < 8; k++) tick();
        imem_ack = 1'b0; retire = 1'b0;
        check("mis_no_req", {31'd0, imem_req}, 32'd0);

        // Reset during WAIT, then a late ack while booting
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("pre_wait_req", {31'd0, imem_req}, 32'd1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_req", {31'd0, imem_req}, 32'd0);
        check("async_PC", PC, 32'h0);
        check("async_Instr", Instr, 32'h0000_0013);
        check("async_count", {16'd0, fetch_count}, 32'd0);
        check("async_misalign", {31'd0, misalign}, 32'd0);
        @(negedge clk);
        compare_all();
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        tick();
        check("late_ack_count", {16'd0, fetch_count}, 32'd0);
        check("late_ack_instr", Instr, 32'h0000_0013);
        fetch_now($urandom);

        // Randomized traffic
        for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
            imem_ack   = ($urandom_range(0, 1) == 1);
            imem_rdata = $urandom;
            retire     = ($urandom_range(0, 2) == 0);
            PCSrc      = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 63) * 4) - 32'd128;
            if ($urandom_range(0, 39) == 0) r = r + $urandom_range(1, 3);
            ImmExt = r;
            rst = !((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
